cache_ctrl: RTL
===============

CACHE_CTRL -- requirements
Module: cache_ctrl

Interface
REQ-001 clk  in  1  single system clock; all state updates on rising edge.
REQ-002 rst  in  1  asynchronous, active-high reset.
REQ-003 Addr  in  16  CPU byte address: tag=[15:11], index=[10:3], offset=[2:0], word-aligned (Addr[0]=0).
REQ-004 DataIn  in  16  CPU write data. Rd, Wr  in  1 each  CPU request strobes, sampled only in IDLE.
REQ-005 DataOut  out  16  read data, valid when Done=1. Done, Stall, CacheHit, err  out  1 each.
REQ-006 c_enable, c_comp, c_write, c_valid_in  out  1 each; c_index out 8; c_offset out 3; c_tag_in out 5; c_data_in out 16: cache-array port.
REQ-007 c_hit, c_dirty, c_valid  in  1 each; c_tag_out in 5; c_data_out in 16: combinational cache-array outputs for the presented index/offset.
REQ-008 m_addr out 16; m_data_in out 16; m_wr, m_rd out 1: main-memory port; m_data_out in 16; m_stall in 1.

Function
REQ-009 States SHALL be IDLE, WB, RD, FILL, RETRY; encoding constants SHALL be shared.
REQ-010 IDLE with Rd^Wr: controller SHALL present compare access (c_enable=1, c_comp=1, c_write=Wr) with Addr fields, DataIn, and latch Addr/DataIn/Wr.
REQ-011 IDLE hit (c_hit & c_valid): Done=1, CacheHit=1, DataOut=c_data_out in that same cycle; stay IDLE.
REQ-012 IDLE miss: victim c_valid & c_dirty -> WB with word counter 0; otherwise -> RD with counter 0; Stall=1 from next cycle until Done.
REQ-013 Rd & Wr both high in IDLE: err=1 for one cycle, no cache or memory access, stay IDLE.
REQ-014 WB: each cycle read cache word k (c_comp=0, c_write=0) and drive m_wr=1, m_addr={victim tag,index,k,0}, m_data_in=c_data_out; k advances only when m_stall=0; after k=3 accepted -> RD, counter 0.
REQ-015 RD: drive m_rd=1, m_addr={latched tag,index,k,0}; k advances when m_stall=0; after k=3 accepted -> FILL.
REQ-016 Read return latency SHALL be exactly 2 cycles after an accepted m_rd; a 2-deep pending pipe (valid + offset per stage) SHALL track returns independently of m_stall.
REQ-017 When pipe stage 2 is valid: install c_offset=pending offset, c_comp=0, c_write=1, c_valid_in=1, c_tag_in=latched tag, c_data_in=m_data_out; this write SHALL take priority over nothing else (RD issues use memory, not cache, so no conflict).
REQ-018 FILL: wait until pipe empty, then -> RETRY.
REQ-019 RETRY: repeat REQ-010 compare with latched request; Done=1, CacheHit=0, DataOut=c_data_out (reads); -> IDLE; Stall=0 this cycle.
REQ-020 c_enable=0, m_rd=0, m_wr=0 in any cycle not listed above; Rd/Wr ignored outside IDLE.
REQ-021 Word counter 2 bits, wraps 3->0 only on state exit; offset field = {k,1'b0}.

Reset
REQ-022 rst SHALL force IDLE, counter 0, pipe empty, latched regs 0; all outputs 0 while rst high.
REQ-023 rst mid-WB/RD/FILL SHALL abandon the transaction; memory returns after reset SHALL be ignored; no Done asserted.

Structure
REQ-024 State encodings and address-field widths/positions SHALL live in a shared include/package (cache_ctrl_defs).
REQ-025 Read-return tracker SHALL be one sub-module, mem_ret_pipe (2 stages, valid+2-bit offset).

Verification
REQ-026 Cold read Addr=0x0010: miss, no WB, 4 m_rd (0x0010,12,14,16), 4 installs, RETRY Done with CacheHit=0; repeat read -> Done same cycle, CacheHit=1.
REQ-027 Write 0x0010=0xBEEF after fill, then read 0x0810 (same index, tag 1): WB of 4 words to 0x0010..0x0016 with 0xBEEF at offset 0, then fill, Done.
REQ-028 m_stall high 3 cycles during RD k=1: m_addr held 0x0012, all 4 words installed at correct offsets, no lost return.
REQ-029 Rd=Wr=1 in IDLE: err=1 one cycle, m_rd=m_wr=c_enable=0.
REQ-030 rst asserted during RD k=2: outputs 0 immediately; next read of same address misses and completes normally.

Source files
------------

// File: rtl/cache_ctrl_pkg.sv
// cache_ctrl_defs: shared definitions for the cache controller.
//   - controller state encoding
//   - CPU address field widths/positions (tag [15:11], index [10:3], offset [2:0])
//   - block word counter width and a helper that builds a memory word address
package cache_ctrl_defs;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WB    = 3'd1,
    ST_RD    = 3'd2,
    ST_FILL  = 3'd3,
    ST_RETRY = 3'd4
  } state_t;

  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 16;
  localparam int TAG_W   = 5;
  localparam int IDX_W   = 8;
  localparam int OFF_W   = 3;
  localparam int K_W     = 2;   // word-in-block counter
  localparam int TAG_LSB = 11;
  localparam int IDX_LSB = 3;

  // Byte address of word k of the block {tag, index}.
  function automatic logic [ADDR_W-1:0] mk_addr(input logic [TAG_W-1:0] tag,
                                                input logic [IDX_W-1:0] idx,
                                                input logic [K_W-1:0]   k);
    return {tag, idx, k, 1'b0};
  endfunction

endpackage

// File: rtl/cache_ctrl_ret.sv
// mem_ret_pipe: tracks outstanding main-memory reads.
// Memory returns data exactly two cycles after an accepted read, regardless of
// m_stall, so a plain two-stage shift of (valid, word offset) lines each
// returned word up with the offset it belongs to.
//   clk, rst  : clock, async active-high reset (clears all pending entries)
//   i_vld     : a read was accepted this cycle
//   i_off     : word index k of that read
//   o_vld     : returning data is on m_data_out this cycle
//   o_off     : word index of the returning data
//   o_empty   : no read outstanding
module mem_ret_pipe
  import cache_ctrl_defs::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           i_vld,
  input  logic [K_W-1:0] i_off,
  output logic           o_vld,
  output logic [K_W-1:0] o_off,
  output logic           o_empty
);

  logic [2:1]     r_vld;
  logic [K_W-1:0] r_off1;
  logic [K_W-1:0] r_off2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld  <= '0;
      r_off1 <= '0;
      r_off2 <= '0;
    end else begin
      r_vld  <= {r_vld[1], i_vld};
      r_off1 <= i_off;
      r_off2 <= r_off1;
    end
  end

  assign o_vld   = r_vld[2];
  assign o_off   = r_off2;
  assign o_empty = ~|r_vld;

endmodule

// File: rtl/cache_ctrl.sv
// cache_ctrl: write-back, allocate-on-miss controller between a CPU and a
// direct-mapped 4-word-block cache array, backed by a pipelined main memory.
//   CPU    : Addr, DataIn, Rd, Wr in; DataOut, Done, Stall, CacheHit, err out
//   Cache  : c_enable/c_comp/c_write/c_valid_in, c_index/c_offset/c_tag_in/c_data_in out;
//            c_hit/c_dirty/c_valid/c_tag_out/c_data_out in (combinational)
//   Memory : m_addr/m_data_in/m_wr/m_rd out; m_data_out/m_stall in
// Miss flow: IDLE -> (WB if dirty victim) -> RD -> FILL -> RETRY -> IDLE.
module cache_ctrl
  import cache_ctrl_defs::*;
(
  input  logic              clk,
  input  logic              rst,
  // CPU
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] DataIn,
  input  logic              Rd,
  input  logic              Wr,
  output logic [DATA_W-1:0] DataOut,
  output logic              Done,
  output logic              Stall,
  output logic              CacheHit,
  output logic              err,
  // cache array
  output logic              c_enable,
  output logic              c_comp,
  output logic              c_write,
  output logic              c_valid_in,
  output logic [IDX_W-1:0]  c_index,
  output logic [OFF_W-1:0]  c_offset,
  output logic [TAG_W-1:0]  c_tag_in,
  output logic [DATA_W-1:0] c_data_in,
  input  logic              c_hit,
  input  logic              c_dirty,
  input  logic              c_valid,
  input  logic [TAG_W-1:0]  c_tag_out,
  input  logic [DATA_W-1:0] c_data_out,
  // main memory
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_data_in,
  output logic              m_wr,
  output logic              m_rd,
  input  logic [DATA_W-1:0] m_data_out,
  input  logic              m_stall
);

  state_t            r_state, w_state_nxt;
  logic [K_W-1:0]    r_k, w_k_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_din;
  logic              r_wr;
  logic [TAG_W-1:0]  r_vtag;
  logic              w_latch;
  logic              w_issue;
  logic              w_ret_vld;
  logic [K_W-1:0]    w_ret_off;
  logic              w_pipe_empty;

  logic [TAG_W-1:0]  w_tag;
  logic [IDX_W-1:0]  w_idx;
  assign w_tag = r_addr[TAG_LSB +: TAG_W];
  assign w_idx = r_addr[IDX_LSB +: IDX_W];

  mem_ret_pipe u_ret (
    .clk     (clk),
    .rst     (rst),
    .i_vld   (w_issue),
    .i_off   (r_k),
    .o_vld   (w_ret_vld),
    .o_off   (w_ret_off),
    .o_empty (w_pipe_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_k     <= '0;
      r_addr  <= '0;
      r_din   <= '0;
      r_wr    <= 1'b0;
      r_vtag  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_k     <= w_k_nxt;
      if (w_latch) begin
        r_addr <= Addr;
        r_din  <= DataIn;
        r_wr   <= Wr;
        r_vtag <= c_tag_out;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_latch     = 1'b0;
    w_issue     = 1'b0;
    DataOut     = '0;
    Done        = 1'b0;
    Stall       = 1'b0;
    CacheHit    = 1'b0;
    err         = 1'b0;
    c_enable    = 1'b0;
    c_comp      = 1'b0;
    c_write     = 1'b0;
    c_valid_in  = 1'b0;
    c_index     = '0;
    c_offset    = '0;
    c_tag_in    = '0;
    c_data_in   = '0;
    m_addr      = '0;
    m_data_in   = '0;
    m_wr        = 1'b0;
    m_rd        = 1'b0;

    // Everything is held at 0 while reset is high, including the
    // combinational IDLE compare path that would otherwise follow Rd/Wr.
    if (!rst) begin
      Stall = (r_state == ST_WB) || (r_state == ST_RD) || (r_state == ST_FILL);
      unique case (r_state)
        ST_IDLE: begin
          if (Rd && Wr) begin
            err = 1'b1;
          end else if (Rd || Wr) begin
            c_enable   = 1'b1;
            c_comp     = 1'b1;
            c_write    = Wr;
            c_valid_in = 1'b1;
            c_index    = Addr[IDX_LSB +: IDX_W];
            c_offset   = Addr[OFF_W-1:0];
            c_tag_in   = Addr[TAG_LSB +: TAG_W];
            c_data_in  = DataIn;
            if (c_hit && c_valid) begin
              Done     = 1'b1;
              CacheHit = 1'b1;
              DataOut  = c_data_out;
            end else begin
              // c_tag_out is the victim's tag; it is latched with the request.
              w_latch     = 1'b1;
              w_k_nxt     = '0;
              w_state_nxt = (c_valid && c_dirty) ? ST_WB : ST_RD;
            end
          end
        end
        ST_WB: begin
          c_enable  = 1'b1;
          c_index   = w_idx;
          c_offset  = {r_k, 1'b0};
          m_wr      = 1'b1;
          m_addr    = mk_addr(r_vtag, w_idx, r_k);
          m_data_in = c_data_out;
          if (!m_stall) begin
            w_k_nxt = r_k + 2'd1;
            if (r_k == 2'd3) w_state_nxt = ST_RD;
          end
        end
        ST_RD: begin
          m_rd   = 1'b1;
          m_addr = mk_addr(w_tag, w_idx, r_k);
          if (!m_stall) begin
            w_issue = 1'b1;
            w_k_nxt = r_k + 2'd1;
            if (r_k == 2'd3) w_state_nxt = ST_FILL;
          end
        end
        ST_FILL: begin
          if (w_pipe_empty) w_state_nxt = ST_RETRY;
        end
        ST_RETRY: begin
          c_enable    = 1'b1;
          c_comp      = 1'b1;
          c_write     = r_wr;
          c_valid_in  = 1'b1;
          c_index     = w_idx;
          c_offset    = r_addr[OFF_W-1:0];
          c_tag_in    = w_tag;
          c_data_in   = r_din;
          Done        = 1'b1;
          DataOut     = c_data_out;
          w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase

      // Returning fill word. Only possible in RD/FILL, where the cache port
      // is otherwise idle (reads go to memory), so this never collides.
      if (w_ret_vld) begin
        c_enable   = 1'b1;
        c_comp     = 1'b0;
        c_write    = 1'b1;
        c_valid_in = 1'b1;
        c_index    = w_idx;
        c_offset   = {w_ret_off, 1'b0};
        c_tag_in   = w_tag;
        c_data_in  = m_data_out;
      end
    end
  end

endmodule
